// File: rtl/multdiv_pkg.sv
// Shared FSM state encoding, iteration count and divide-by-zero constants for
// the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    localparam int unsigned MD_ITERS      = 32;
    localparam int unsigned MD_CNT_W      = $clog2(MD_ITERS);
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference only when it did not go negative.
module div_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor <= 2^(WIDTH-1) keeps shifted below 2^WIDTH, so bit WIDTH of
    // the difference is a clean borrow flag.
    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide owning HI and LO.
// Build option: define DIV_ZERO_EXC_EN to raise a one-cycle div_zero exception.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    import multdiv_pkg::*;

    localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITERS - 1);

    md_state_t           state;
    logic [MD_CNT_W-1:0] counter;

    logic [WIDTH:0]      acc;
    logic [WIDTH:0]      mcand;
    logic [WIDTH-1:0]    mq;
    logic                qm1;
    logic [WIDTH:0]      acc_sum;
    logic [WIDTH:0]      acc_next;
    logic [WIDTH-1:0]    mq_next;
    logic                qm1_next;

    logic [WIDTH-1:0]    rem;
    logic [WIDTH-1:0]    dvd_q;
    logic [WIDTH-1:0]    dvs_mag;
    logic [WIDTH-1:0]    dividend;
    logic                quo_neg;
    logic                rem_neg;
    logic                dvs_zero;
    logic [WIDTH-1:0]    rem_next;
    logic                q_bit;
    logic [WIDTH-1:0]    quo_final;
    logic [WIDTH-1:0]    div_hi;
    logic [WIDTH-1:0]    div_lo;
    logic [WIDTH-1:0]    rs_mag;
    logic [WIDTH-1:0]    rt_mag;

    assign busy = (state != IDLE);

    always_comb begin
        acc_sum = acc;
        case ({mq[0], qm1})
            2'b01:   acc_sum = acc + mcand;
            2'b10:   acc_sum = acc - mcand;
            default: acc_sum = acc;
        endcase
        {acc_next, mq_next, qm1_next} = {acc_sum[WIDTH], acc_sum, mq};
    end

    always_comb begin
        rs_mag = rs_data[WIDTH-1] ? -rs_data : rs_data;
        rt_mag = rt_data[WIDTH-1] ? -rt_data : rt_data;
    end

    div_restore_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem      (rem),
        .dvd_bit  (dvd_q[WIDTH-1]),
        .divisor  (dvs_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // dvd_q shifts dividend bits out of the top while quotient bits enter at
    // the bottom, so after the last step it holds the full quotient magnitude.
    always_comb begin
        quo_final = {dvd_q[WIDTH-2:0], q_bit};
        if (dvs_zero) begin
            div_hi = dividend;
            div_lo = WIDTH'(DIV_ZERO_QUOT);
        end else begin
            div_hi = rem_neg ? -rem_next : rem_next;
            div_lo = quo_neg ? -quo_final : quo_final;
        end
    end

`ifndef DIV_ZERO_EXC_EN
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            done     <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
            div_zero <= 1'b0;
`endif
            acc      <= '0;
            mcand    <= '0;
            mq       <= '0;
            qm1      <= 1'b0;
            rem      <= '0;
            dvd_q    <= '0;
            dvs_mag  <= '0;
            dividend <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            dvs_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
                    div_zero <= 1'b0;
`endif
                    if (MultCtrl) begin
                        state   <= MULT;
                        counter <= CNT_LAST;
                        acc     <= '0;
                        mcand   <= {rs_data[WIDTH-1], rs_data};
                        mq      <= rt_data;
                        qm1     <= 1'b0;
                    end else if (DivCtrl) begin
`ifdef DIV_ZERO_EXC_EN
                        if (rt_data == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            state    <= DIV;
                            counter  <= CNT_LAST;
                            rem      <= '0;
                            dvd_q    <= rs_mag;
                            dvs_mag  <= rt_mag;
                            dividend <= rs_data;
                            quo_neg  <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                            rem_neg  <= rs_data[WIDTH-1];
                            dvs_zero <= (rt_data == '0);
                        end
                    end
                end

                MULT: begin
                    acc <= acc_next;
                    mq  <= mq_next;
                    qm1 <= qm1_next;
                    if (counter == '0) begin
                        hi_out <= acc_next[WIDTH-1:0];
                        lo_out <= mq_next;
                        state  <= DONE;
                        done   <= 1'b1;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end

                DIV: begin
                    rem   <= rem_next;
                    dvd_q <= quo_final;
                    if (counter == '0) begin
                        hi_out <= div_hi;
                        lo_out <= div_lo;
                        state  <= DONE;
                        done   <= 1'b1;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end

                DONE: begin
                    done <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
                    div_zero <= 1'b0;
`endif
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases then random
// operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MultCtrl = 1'b0;
    logic        DivCtrl = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int unsigned total = 0;
    int unsigned passed = 0;
    int unsigned fails = 0;

    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mult_div_unit #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MultCtrl (MultCtrl),
        .DivCtrl  (DivCtrl),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic; latency counted in edges after the start edge.
    task automatic model(input bit m, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int lat, output logic dz);
        longint sa, sb, p, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 32;
        dz  = 1'b0;
        if (m) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
`ifdef DIV_ZERO_EXC_EN
            lat = 0;
            dz  = 1'b1;
            hi  = model_hi;
            lo  = model_lo;
`else
            hi = a;
            lo = 32'hFFFF_FFFF;
`endif
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    task automatic run_op(input string tag, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [31:0] exp_hi, exp_lo;
        logic        exp_dz, dz_seen;
        int          exp_lat, lat;
        bit          hold_ok;
        model(m, a, b, exp_hi, exp_lo, exp_lat, exp_dz);
        hold_ok = 1'b1;
        dz_seen = 1'b0;
        lat     = -1;
        @(negedge clk);
        MultCtrl = m;
        DivCtrl  = d;
        rs_data  = a;
        rt_data  = b;
        @(posedge clk);
        #1;
        MultCtrl = 1'b0;
        DivCtrl  = 1'b0;
        rs_data  = $urandom;
        rt_data  = $urandom;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        for (int k = 0; k <= 40 && lat < 0; k++) begin
            if (k > 0) begin
                if (k == inject) DivCtrl = 1'b1;
                @(posedge clk);
                #1;
                DivCtrl = 1'b0;
            end
            if (done === 1'b1) begin
                lat     = k;
                dz_seen = div_zero;
            end else if (hi_out !== model_hi || lo_out !== model_lo) begin
                hold_ok = 1'b0;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
        check({tag, "_div_zero"}, 64'(dz_seen), 64'(exp_dz));
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {62'd0, done, busy}, 64'd0);
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    initial begin
        bit          done_seen;
        bit          m;
        logic [31:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi_out), 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);
        check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);

        run_op("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mul_min_sq", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0, 0);
        run_op("mul_ign_div", 1'b1, 1'b0, 32'h1234_5678, 32'hFEDC_BA98, 10);
        run_op("both_ctrl", 1'b1, 1'b1, 32'hFFFF_FF00, 32'd300, 0);

        // Reset arrives on the 15th edge after the start edge of a divide.
        @(negedge clk);
        DivCtrl = 1'b1;
        rs_data = 32'hFFFF_FF9C;
        rt_data = 32'd7;
        @(posedge clk);
        #1;
        DivCtrl = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_hi  = '0;
        model_lo  = '0;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        check("rst_mid_no_done", 64'(done_seen), 64'd0);
        run_op("mul_after_rst", 1'b1, 1'b0, 32'd123_456, 32'hFFFF_FC18, 0);

        for (int i = 0; i < 24; i++) begin
            m = $urandom_range(0, 1) == 1;
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'(int'($urandom_range(0, 20)) - 10);
                2:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(m ? "rnd_mul" : "rnd_div", m, ~m, a, b, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
